// File: rtl/bram_port_scheduler.sv
// Shares one simple-dual-port BRAM between the core data port (requester 0)
// and the program loader (requester 1). Each cycle at most one write is
// scheduled on port A and one read on port B. Same-type conflicts are settled
// round-robin. A read that targets the word being written that cycle is
// stalled. Read data comes back on the lane of the requester that issued it.
module bram_port_scheduler #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        bram_wea,
    output logic [31:0] bram_addra,
    output logic [31:0] bram_dina,
    output logic [31:0] bram_addrb,
    input  logic [31:0] bram_doutb
);

    // A request is bad if it is misaligned or lies beyond the RAM depth.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_BITS + 2)) != 32'd0);
    endfunction

    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0] pipe_own_q, pipe_own_d;
    logic [READ_LATENCY-1:0] pipe_err_q, pipe_err_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [63:0]             rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_err_q, rsp_err_d;

    logic [1:0]  wcand, rcand;
    logic        w_any, w_sel, w_good;
    logic        r_any, r_sel, r_go, collide;
    logic [31:0] w_addr, w_data, r_addr;

    // Arbitration, collision check and port A/B drive for the current cycle.
    always_comb begin
        wcand    = req_valid & req_we;
        rcand    = req_valid & ~req_we;
        w_any    = rstn && (wcand != 2'b00);
        r_any    = rstn && (rcand != 2'b00);
        w_sel    = (wcand == 2'b11) ? wr_ptr_q : wcand[1];
        r_sel    = (rcand == 2'b11) ? rd_ptr_q : rcand[1];
        w_addr   = w_sel ? req_addr[63:32]  : req_addr[31:0];
        w_data   = w_sel ? req_wdata[63:32] : req_wdata[31:0];
        r_addr   = r_sel ? req_addr[63:32]  : req_addr[31:0];
        w_good   = !addr_bad(w_addr);
        // Only a real write to the same word can corrupt the read, so a bad
        // write never stalls a reader.
        collide  = w_any && w_good && (w_addr[ADDR_BITS+1:2] == r_addr[ADDR_BITS+1:2]);
        r_go     = r_any && !collide;

        req_ready = 2'b00;
        if (w_any) req_ready = req_ready | {w_sel, ~w_sel};
        if (r_go)  req_ready = req_ready | {r_sel, ~r_sel};

        wr_ptr_d = (w_any && wcand == 2'b11) ? ~w_sel : wr_ptr_q;
        rd_ptr_d = (r_go && rcand == 2'b11)  ? ~r_sel : rd_ptr_q;

        bram_wea   = w_any && w_good;
        bram_addra = bram_wea ? w_addr : 32'd0;
        bram_dina  = bram_wea ? w_data : 32'd0;
        bram_addrb = r_go ? r_addr : 32'd0;
    end

    // Response tracking pipeline aligned to the BRAM read latency, plus the
    // registered response lanes built from its tail.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_own_d    = '0;
        pipe_err_d    = '0;
        pipe_vld_d[0] = r_go;
        pipe_own_d[0] = r_sel;
        pipe_err_d[0] = addr_bad(r_addr);
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_own_d[i] = pipe_own_q[i-1];
            pipe_err_d[i] = pipe_err_q[i-1];
        end

        rsp_valid_d = 2'b00;
        rsp_rdata_d = 64'd0;
        rsp_err_d   = 2'b00;
        if (pipe_vld_q[READ_LATENCY-1]) begin
            if (pipe_own_q[READ_LATENCY-1]) begin
                rsp_valid_d[1]     = 1'b1;
                rsp_err_d[1]       = pipe_err_q[READ_LATENCY-1];
                rsp_rdata_d[63:32] = pipe_err_q[READ_LATENCY-1] ? 32'd0 : bram_doutb;
            end else begin
                rsp_valid_d[0]     = 1'b1;
                rsp_err_d[0]       = pipe_err_q[READ_LATENCY-1];
                rsp_rdata_d[31:0]  = pipe_err_q[READ_LATENCY-1] ? 32'd0 : bram_doutb;
            end
        end
    end

    // State update; reset drops any in-flight reads and re-centres priority on requester 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_own_q  <= '0;
            pipe_err_q  <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 2'b00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_own_q  <= pipe_own_d;
            pipe_err_q  <= pipe_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bram_port_scheduler.sv
// Bench for bram_port_scheduler with a behavioural 1-cycle-latency BRAM.
module tb_bram_port_scheduler;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        bram_wea;
    logic [31:0] bram_addra, bram_dina, bram_addrb, bram_doutb;

    int checks   = 0;
    int failures = 0;

    bram_port_scheduler #(.ADDR_BITS(10), .READ_LATENCY(1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: write on port A, registered read on port B.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bram_wea) mem[bram_addra[11:2]] <= bram_dina;
        bram_doutb <= mem[bram_addrb[11:2]];
    end

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  rdy;
        logic        wea;
        logic [31:0] addra, dina, addrb;
        logic [1:0]  rv;
        logic [63:0] rd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic [1:0] v, logic [1:0] we, logic [31:0] a0, logic [31:0] a1,
                                logic [31:0] d0, logic [31:0] d1, logic [1:0] rdy, logic wea,
                                logic [31:0] addra, logic [31:0] dina, logic [31:0] addrb,
                                logic [1:0] rv, logic [63:0] rd);
        vec_t t;
        t.valid = v; t.we = we; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.rdy = rdy; t.wea = wea; t.addra = addra; t.dina = dina; t.addrb = addrb;
        t.rv = rv; t.rd = rd;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // rv/rd are the responses visible just after this row's clock edge,
        // i.e. from the read granted in the previous row.
        tbl[0]  = mk(2'b00, 2'b00, 32'h0,  32'h0,  32'h0,        32'h0,        2'b00, 1'b0, 32'h0,  32'h0,        32'h0,  2'b00, 64'h0);
        tbl[1]  = mk(2'b01, 2'b01, 32'h10, 32'h0,  32'hDEADBEEF, 32'h0,        2'b01, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0,  2'b00, 64'h0);
        tbl[2]  = mk(2'b11, 2'b10, 32'h10, 32'h20, 32'h0,        32'h12345678, 2'b11, 1'b1, 32'h20, 32'h12345678, 32'h10, 2'b00, 64'h0);
        tbl[3]  = mk(2'b11, 2'b00, 32'h10, 32'h20, 32'h0,        32'h0,        2'b01, 1'b0, 32'h0,  32'h0,        32'h10, 2'b01, 64'h00000000_DEADBEEF);
        tbl[4]  = mk(2'b11, 2'b00, 32'h10, 32'h20, 32'h0,        32'h0,        2'b10, 1'b0, 32'h0,  32'h0,        32'h20, 2'b01, 64'h00000000_DEADBEEF);
        tbl[5]  = mk(2'b01, 2'b01, 32'h3,  32'h0,  32'h55,       32'h0,        2'b01, 1'b0, 32'h0,  32'h0,        32'h0,  2'b10, 64'h12345678_00000000);
        tbl[6]  = mk(2'b11, 2'b11, 32'h30, 32'h34, 32'h30303030, 32'h34343434, 2'b01, 1'b1, 32'h30, 32'h30303030, 32'h0,  2'b00, 64'h0);
        tbl[7]  = mk(2'b11, 2'b11, 32'h30, 32'h34, 32'h30303030, 32'h34343434, 2'b10, 1'b1, 32'h34, 32'h34343434, 32'h0,  2'b00, 64'h0);
        tbl[8]  = mk(2'b11, 2'b10, 32'h40, 32'h40, 32'h0,        32'hAAAA5555, 2'b10, 1'b1, 32'h40, 32'hAAAA5555, 32'h0,  2'b00, 64'h0);
        tbl[9]  = mk(2'b01, 2'b00, 32'h40, 32'h0,  32'h0,        32'h0,        2'b01, 1'b0, 32'h0,  32'h0,        32'h40, 2'b00, 64'h0);
        tbl[10] = mk(2'b00, 2'b00, 32'h0,  32'h0,  32'h0,        32'h0,        2'b00, 1'b0, 32'h0,  32'h0,        32'h0,  2'b01, 64'h00000000_AAAA5555);

        // Reset: requests present but nothing granted or written.
        rstn = 1'b0;
        drive(2'b11, 2'b11, 32'h10, 32'h20, 32'h1, 32'h2);
        chk("rst_ready", 64'(req_ready), 64'(2'b00));
        chk("rst_wea",   64'(bram_wea),  64'(1'b0));
        step();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
        chk("rst_rsp_rdata", rsp_rdata,      64'h0);
        chk("rst_rsp_err",   64'(rsp_err),   64'(2'b00));
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        rstn = 1'b1;
        step();

        // Table: basic grants, concurrent write+read, round-robin, bad write, collision.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            chk($sformatf("v%0d_ready", i), 64'(req_ready),  64'(tbl[i].rdy));
            chk($sformatf("v%0d_wea", i),   64'(bram_wea),   64'(tbl[i].wea));
            chk($sformatf("v%0d_addra", i), 64'(bram_addra), 64'(tbl[i].addra));
            chk($sformatf("v%0d_dina", i),  64'(bram_dina),  64'(tbl[i].dina));
            chk($sformatf("v%0d_addrb", i), 64'(bram_addrb), 64'(tbl[i].addrb));
            step();
            chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].rv));
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata,      tbl[i].rd);
            chk($sformatf("v%0d_rsp_err", i),   64'(rsp_err),   64'(2'b00));
        end

        // Two readers held for 6 cycles: grants and responses alternate 0,1,...
        for (int k = 0; k < 8; k++) begin
            if (k < 6) drive(2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
            else       drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            if (k < 6) chk($sformatf("rr_rd%0d_ready", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            step();
            if (k == 0)
                chk("rr_rd0_rsp_valid", 64'(rsp_valid), 64'h0);
            else if (k <= 6) begin
                chk($sformatf("rr_rd%0d_rsp_valid", k), 64'(rsp_valid), ((k - 1) % 2 == 0) ? 64'h1 : 64'h2);
                chk($sformatf("rr_rd%0d_rsp_rdata", k), rsp_rdata,
                    ((k - 1) % 2 == 0) ? 64'h00000000_DEADBEEF : 64'h12345678_00000000);
            end else
                chk("rr_rd7_rsp_valid", 64'(rsp_valid), 64'h0);
        end

        // Two writers held for 4 cycles: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'b11, 32'h50, 32'h54, 32'h11111111, 32'h22222222);
            chk($sformatf("rr_wr%0d_ready", k), 64'(req_ready),  (k % 2 == 0) ? 64'h1 : 64'h2);
            chk($sformatf("rr_wr%0d_addra", k), 64'(bram_addra), (k % 2 == 0) ? 64'h50 : 64'h54);
            step();
        end

        // Bad reads: word 0 holds non-zero data, both bad addresses alias onto it.
        drive(2'b01, 2'b01, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0);
        step();
        drive(2'b01, 2'b00, 32'h1002, 32'h0, 32'h0, 32'h0);
        chk("bad_rd0_ready", 64'(req_ready), 64'h1);
        step();
        drive(2'b10, 2'b00, 32'h0, 32'h1000, 32'h0, 32'h0);
        chk("bad_rd1_ready", 64'(req_ready), 64'h2);
        step();
        chk("bad_rd0_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("bad_rd0_rsp_err",   64'(rsp_err),   64'h1);
        chk("bad_rd0_rsp_rdata", rsp_rdata,      64'h0);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("bad_rd1_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("bad_rd1_rsp_err",   64'(rsp_err),   64'h2);
        chk("bad_rd1_rsp_rdata", rsp_rdata,      64'h0);
        drive(2'b01, 2'b01, 32'h3, 32'h0, 32'h77, 32'h0);
        chk("bad_wr_ready", 64'(req_ready), 64'h1);
        chk("bad_wr_wea",   64'(bram_wea),  64'h0);
        step();

        // Move both pointers to requester 1, then reset with a read in flight.
        drive(2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
        chk("pre_rst_rd_ready", 64'(req_ready), 64'h1);
        step();
        drive(2'b11, 2'b11, 32'h30, 32'h34, 32'h5, 32'h6);
        chk("pre_rst_wr_ready", 64'(req_ready), 64'h1);
        step();
        drive(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
        chk("inflight_ready", 64'(req_ready), 64'h1);
        step();
        drive(2'b11, 2'b11, 32'h10, 32'h20, 32'h0, 32'h0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        chk("mid_rst_wea",   64'(bram_wea),  64'h0);
        step();
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst%0d_rsp_valid", k), 64'(rsp_valid), 64'h0);
        end
        drive(2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
        chk("post_rst_rd_winner", 64'(req_ready), 64'h1);
        step();
        drive(2'b11, 2'b11, 32'h30, 32'h34, 32'h5, 32'h6);
        chk("post_rst_wr_winner", 64'(req_ready), 64'h1);
        step();
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_port_scheduler.md
Name: bram_port_scheduler

Overview:
- Shares one simple-dual-port block RAM (write port A, read port B, 32-bit words, byte addressing) between two requesters: requester 0 = core data port, requester 1 = program loader.
- Each cycle it schedules at most one write onto port A and at most one read onto port B.
- It resolves same-type conflicts round-robin and stalls reads that hit the word being written that cycle.
- It routes fixed-latency read data back to the issuing requester.

Parameters:
- ADDR_BITS, 10, word-address width of the BRAM (depth 2^ADDR_BITS words).
- READ_LATENCY, 1, cycles from read issue to bram_rdata valid (1 or 2).

Ports:
- clk  input  1  single clock.
- rstn  input  1  synchronous active-low reset.
- req_valid  input  2  per-requester request valid; bit i = requester i (same indexing for all 2-wide ports).
- req_ready  output  2  per-requester grant; handshake = valid & ready.
- req_we  input  2  1 = write, 0 = read.
- req_addr  input  64  byte addresses; requester i uses [32i+31:32i].
- req_wdata  input  64  write data, same packing.
- rsp_valid  output  2  read response valid.
- rsp_rdata  output  64  read response data.
- rsp_err  output  2  response flags a bad address.
- bram_wea  output  1  port A write enable.
- bram_addra  output  32  port A byte address.
- bram_dina  output  32  port A write data.
- bram_addrb  output  32  port B byte address.
- bram_doutb  input  32  port B read data.

Behaviour:
- Reset (rstn=0 at posedge):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Response pipeline cleared; both priority pointers point to requester 0.
  - While rstn=0, req_ready=0 and bram_wea=0.
  - A reset mid-flight discards all in-flight reads; no response is ever produced for them.
- Address check:
  - Bad if addr[1:0]!=0 or addr[31:ADDR_BITS+2]!=0.
  - A bad request is still granted through normal arbitration.
  - A bad write does not assert bram_wea.
  - A bad read occupies port B for its issue cycle and returns rsp_err=1, rsp_rdata=0 at normal latency.
- Write scheduling:
  - Candidates are requesters with valid & we.
  - One candidate: grant it.
  - Two candidates: grant the one the write pointer selects, then set the write pointer to the loser.
  - Granted good write: bram_wea=1, bram_addra=addr, bram_dina=wdata, all combinational in the same cycle.
  - When no write is granted: bram_wea=0, bram_addra=0, bram_dina=0.
- Read scheduling:
  - Candidates are requesters with valid & !we.
  - Same round-robin scheme, using an independent read pointer.
  - bram_addrb = granted address, or 0 when no read is granted.
- Collision rule:
  - If the granted write is good and the chosen read has the same addr[ADDR_BITS+1:2], the read is not granted that cycle (req_ready=0).
  - The read pointer is not updated on a collision stall.
  - The other reader is not substituted.
  - The read retries next cycle.
- Grant signalling and throughput:
  - req_ready is combinational from req_valid/req_we/req_addr and the pointers.
  - Peak throughput is one write plus one read per cycle.
- Response pipeline:
  - A READ_LATENCY-deep shift register of {valid, owner, err}, filled on each read grant.
  - At the tail: rsp_valid[owner] pulses for exactly 1 cycle.
  - rsp_rdata[owner] = err ? 0 : bram_doutb; rsp_err[owner] = err. All are registered.
  - Response latency = READ_LATENCY+1 cycles from the handshake edge.
  - Back-to-back reads produce back-to-back responses, in issue order.
  - Non-owner response lanes hold 0.
- Ordering: a write handshaken in cycle N is visible to a read issued in cycle N+1 or later.

Test Plan:
- Read after reset, READ_LATENCY=1: pre-write 0xDEADBEEF to addr 0x10, then requester 0 reads 0x10 → ready=1 same cycle; rsp_valid[0]=1 with rsp_rdata=0xDEADBEEF 2 cycles after the handshake; rsp_err=0.
- Concurrent write and read: requester 1 writes 0x12345678 to 0x20 while requester 0 reads 0x24 in the same cycle → both ready=1, bram_wea=1, bram_addrb=0x24; a following read of 0x20 returns 0x12345678.
- Collision: both requesters target 0x40 in the same cycle, requester 1 writing 0xAAAA5555 and requester 0 reading → read ready=0 that cycle and ready=1 next cycle; response = 0xAAAA5555.
- Round-robin: both requesters hold read requests for 6 cycles → grants alternate 0,1,0,1,0,1; responses alternate lanes with correct data; symmetric check for two writers.
- Bad addresses: read 0x1002 and read 0x00001000 (ADDR_BITS=10) → each granted, rsp_err=1, rsp_rdata=0; write to 0x3 → granted, bram_wea stays 0.
- Reset mid-flight: issue a read, drive rstn=0 on the next edge → no rsp_valid afterwards; both pointers back to 0; after release, requester 0 wins the first two-way conflict.
